// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 16-bit core.
// Also holds the condition code register {N,C,Z} and its one-entry interrupt shadow.
module ex_mem_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [2:0]        alu_flag,
    input  logic [2:0]        flag_we,
    input  logic [2:0]        flag_set,
    input  logic [2:0]        flag_clr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              int_save,
    input  logic              rti_restore,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_out,
    output logic [REG_AW-1:0] mem_rd,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [2:0]        ccr
);

    localparam int unsigned FLAG_W = 3;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [FLAG_W-1:0] ccr_q, ccr_d;
    logic [FLAG_W-1:0] shadow_q, shadow_d;
    logic              ex_update;

    // Next-state for the pipeline fields, CCR and shadow
    always_comb begin
        valid_d     = valid_q;
        alu_d       = alu_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        store_d     = store_q;
        ccr_d       = ccr_q;
        shadow_d    = shadow_q;
        ex_update   = ex_valid & ~stall & ~flush;

        if (flush) begin
            // Bubble: kill valid/control, leave data fields untouched
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!stall) begin
            valid_d     = ex_valid;
            alu_d       = alu_out;
            rd_d        = ex_rd;
            store_d     = ex_store_data;
            reg_write_d = ex_valid & ex_reg_write;
            mem_read_d  = ex_valid & ex_mem_read;
            mem_write_d = ex_valid & ex_mem_write;
        end

        if (ex_update) begin
            for (int unsigned i = 0; i < FLAG_W; i++) begin
                if (flag_set[i]) begin
                    ccr_d[i] = 1'b1;
                end else if (flag_clr[i]) begin
                    ccr_d[i] = 1'b0;
                end else if (flag_we[i]) begin
                    ccr_d[i] = alu_flag[i];
                end
            end
        end

        // Shadow path works through stall/flush; both at once swaps CCR and shadow
        if (rti_restore) begin
            ccr_d = shadow_q;
        end
        if (int_save) begin
            shadow_d = ccr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            store_q     <= '0;
            ccr_q       <= '0;
            shadow_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            store_q     <= store_d;
            ccr_q       <= ccr_d;
            shadow_q    <= shadow_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_out    = alu_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_store_data = store_q;
    assign ccr            = ccr_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline boundary directly downstream of the execute-stage ALU in the 16-bit pipelined processor.
- Each cycle it registers the ALU result and the memory/write-back control of the instruction leaving EX into the MEM stage.
- It owns the condition code register (CCR: Negative, Carry, Zero), updated from the ALU flag vector under per-flag write enables and explicit set/clear.
- It holds a one-entry shadow CCR for interrupt entry and RTI.

Parameters:
- DATA_W, 16, datapath width of ALU result and store data
- REG_AW, 3, register-file address width (8 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit freeze; holds all state except shadow/restore path
- flush  in  1  kill the instruction in EX; insert bubble
- ex_valid  in  1  EX holds a real instruction
- alu_out  in  DATA_W  ALU result
- alu_flag  in  3  ALU flags {N,C,Z}; bit2=N, bit1=C, bit0=Z
- flag_we  in  3  per-flag update enable, same bit order
- flag_set  in  3  force flag to 1 (SETC)
- flag_clr  in  3  force flag to 0 (CLRC)
- ex_rd  in  REG_AW  destination register
- ex_reg_write  in  1  write-back enable
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_store_data  in  DATA_W  store operand
- int_save  in  1  interrupt entry: copy CCR to shadow
- rti_restore  in  1  RTI: copy shadow to CCR
- mem_valid  out  1  MEM-stage instruction valid
- mem_alu_out  out  DATA_W  registered result / memory address
- mem_rd  out  REG_AW  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered control
- mem_store_data  out  DATA_W  registered store operand
- ccr  out  3  architectural flags {N,C,Z}

Behaviour:
- Reset (rst=1 at edge): every output 0, CCR 0, shadow 0. Reset overrides stall, flush, save and restore in the same cycle.
- Latency: one cycle from EX inputs to mem_* outputs. CCR is visible one cycle after the updating instruction is in EX.
- Advance (stall=0, flush=0): every mem_* output is loaded from its EX counterpart. mem_valid=ex_valid.
- Advance with ex_valid=0: mem_reg_write, mem_mem_read and mem_mem_write are forced to 0.
- Stall (stall=1, flush=0): all mem_* outputs hold; the CCR does not take the EX update.
- Flush (flush=1, with or without stall): mem_valid and the three mem_* control bits are 0. Data fields (mem_alu_out, mem_rd, mem_store_data) hold. No CCR update. Flush wins over stall.
- CCR update, only when ex_valid & ~stall & ~flush, evaluated independently per bit i, in priority order:
  - flag_set[i] → 1
  - else flag_clr[i] → 0
  - else flag_we[i] → alu_flag[i]
  - else hold
- int_save: shadow takes the current registered CCR, i.e. the value before this edge's update. Acts regardless of stall and flush.
- rti_restore: CCR takes the shadow, overriding any EX update in the same cycle. Acts regardless of stall and flush.
- int_save and rti_restore together: CCR takes the old shadow; shadow takes the old CCR (swap).
- alu_flag bits whose flag_we=0 are ignored. No X/Z values propagate into the CCR.
- No combinational path from inputs to outputs.

Test Plan:
- Reset with rst=1 for 2 cycles while inputs are nonzero → all outputs 0. Release; ex_valid=1, alu_out=16'h1234, ex_rd=3, ex_reg_write=1 → next cycle mem_alu_out=16'h1234, mem_rd=3, mem_reg_write=1, mem_valid=1.
- ADD producing alu_flag=3'b011 with flag_we=3'b111 → ccr=3'b011. Next, NOT with alu_flag=3'b100 and flag_we=3'b101 → ccr=3'b110 (carry held).
- flag_set=3'b010 and flag_clr=3'b010 in the same cycle with flag_we=3'b010, alu_flag=0 → C=1 (set wins). Next, flag_clr=3'b010 only → C=0.
- stall=1 for 3 cycles with changing EX inputs and flag_we=3'b111 → mem_* and ccr constant. Then flush=1 together with stall=1 → mem_valid=0, all control bits 0, ccr unchanged.
- ccr=3'b101, int_save=1 → shadow=3'b101. Then update ccr to 3'b010. rti_restore=1 concurrent with an EX update to 3'b111 → ccr=3'b101.
- int_save and rti_restore together with ccr=3'b001, shadow=3'b100 → ccr=3'b100, shadow=3'b001. Asserting rst during a stalled store → all outputs 0 on the next edge.
